// File: rtl/rv_dmem_pkg.sv
// rtl/rv_dmem_pkg.sv - shared types and lane helpers for rv_dmem
// Purpose: access-size and FSM state enums, plus byte-enable, lane-mask and
// load-extension helpers. Helpers work on a 64-bit (8-lane) view; callers
// narrow the result to their own word width.
package rv_dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Low-address bits that must be zero for an access of this size.
  function automatic logic [2:0] lane_mask(input size_e size);
    case (size)
      SZ_B:    return 3'd0;
      SZ_H:    return 3'd1;
      SZ_W:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // One bit per byte lane touched by an access of this size at this offset.
  function automatic logic [7:0] byte_en(input size_e size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // raw holds the addressed bytes right-aligned; extend from the access width.
  function automatic logic [63:0] extend_load(input logic [63:0] raw, input size_e size,
                                              input logic uns);
    case (size)
      SZ_B:    return uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SZ_H:    return uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    return uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/rv_dmem_bank.sv
// rtl/rv_dmem_bank.sv - DEPTH x WORDL storage with byte-enable write and registered read
// Ports:
//   i_clk            clock
//   i_we, i_be       write strobe and per-byte lane enables
//   i_addr           word index shared by read and write
//   i_wdata          lane-positioned write data
//   i_re             read strobe; o_rdata updates on the following edge
//   o_rdata          registered read data
module rv_dmem_bank #(
  parameter int DEPTH = 256,
  parameter int WORDL = 32,
  parameter int IDX_W = 8
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [WORDL/8-1:0] i_be,
  input  logic [IDX_W-1:0]   i_addr,
  input  logic [WORDL-1:0]   i_wdata,
  input  logic               i_re,
  output logic [WORDL-1:0]   o_rdata
);

  logic [WORDL-1:0] r_mem [DEPTH];
  logic [WORDL-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < WORDL/8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rv_dmem.sv
// rtl/rv_dmem.sv - byte-addressed data memory with sub-word access and clear-on-reset sweep
// Optional feature macro: RV_DMEM_ALIGN_CHECK_EN (reject misaligned/illegal-size requests).
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_req_valid / o_req_ready    request handshake; ready low during the clear sweep
//   i_req_we, i_req_size         store/load, size 0 byte .. 3 double
//   i_req_unsigned               zero-extend loads when set
//   i_req_addr, i_req_wdata      byte address, right-aligned store data
//   o_rsp_valid                  one-cycle pulse per accepted request
//   o_rsp_rdata, o_rsp_err       extended load data (0 for stores/errors), reject flag
//   o_init_busy                  clear sweep in progress
module rv_dmem
  import rv_dmem_pkg::*;
#(
  parameter int MEMSIZE = 'h400,
  parameter int WORDL   = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_we,
  input  logic [1:0]                 i_req_size,
  input  logic                       i_req_unsigned,
  input  logic [$clog2(MEMSIZE)-1:0] i_req_addr,
  input  logic [WORDL-1:0]           i_req_wdata,
  output logic                       o_rsp_valid,
  output logic [WORDL-1:0]           o_rsp_rdata,
  output logic                       o_rsp_err,
  output logic                       o_init_busy
);

  localparam int NB     = WORDL / 8;
  localparam int DEPTH  = MEMSIZE / NB;
  localparam int ADDR_W = $clog2(MEMSIZE);
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt;

  logic             w_clear, w_accept, w_illegal, w_err;
  size_e            w_size;
  logic [2:0]       w_off, w_mask, w_off_eff;
  logic [IDX_W-1:0] w_idx;
  logic [NB-1:0]    w_be;
  logic [WORDL-1:0] w_wdata_sh;

  logic             w_bank_we, w_bank_re;
  logic [NB-1:0]    w_bank_be;
  logic [IDX_W-1:0] w_bank_addr;
  logic [WORDL-1:0] w_bank_wdata, w_bank_rdata, w_raw;

  logic             r_rsp_valid, r_rsp_load, r_rsp_err, r_uns;
  logic [2:0]       r_off;
  size_e            r_size;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Handshake outputs are also forced by i_reset so no request is taken in a reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_init_busy = 1'b0;
    case (r_state)
      ST_INIT: begin
        o_init_busy = 1'b1;
        if (r_cnt == LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN:  o_req_ready = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
    if (i_reset) begin
      o_req_ready = 1'b0;
      o_init_busy = 1'b1;
    end
  end

  assign w_clear   = (r_state == ST_INIT) && !i_reset;
  assign w_accept  = i_req_valid && o_req_ready;

  // Double accesses do not exist on a 32-bit word; they fall back to word size.
  assign w_illegal = (WORDL == 32) && (i_req_size == 2'd3);
  assign w_size    = w_illegal ? SZ_W : size_e'(i_req_size);
  assign w_off     = 3'(i_req_addr[OFF_W-1:0]);
  assign w_mask    = lane_mask(w_size);
  assign w_idx     = i_req_addr[ADDR_W-1:OFF_W];

`ifdef RV_DMEM_ALIGN_CHECK_EN
  assign w_err     = w_illegal | (|(w_off & w_mask));
  assign w_off_eff = w_off;
`else
  assign w_err     = 1'b0;
  assign w_off_eff = w_off & ~w_mask;
`endif

  assign w_be       = NB'(byte_en(w_size, w_off_eff));
  assign w_wdata_sh = i_req_wdata << {w_off_eff, 3'b000};

  // The clear sweep owns the bank port while in INIT; requests cannot be accepted then.
  always_comb begin
    w_bank_we    = 1'b0;
    w_bank_re    = 1'b0;
    w_bank_be    = w_be;
    w_bank_addr  = w_idx;
    w_bank_wdata = w_wdata_sh;
    if (w_clear) begin
      w_bank_we    = 1'b1;
      w_bank_be    = '1;
      w_bank_addr  = r_cnt;
      w_bank_wdata = '0;
    end else if (w_accept && !w_err) begin
      w_bank_we = i_req_we;
      w_bank_re = !i_req_we;
    end
  end

  rv_dmem_bank #(
    .DEPTH (DEPTH),
    .WORDL (WORDL),
    .IDX_W (IDX_W)
  ) u_bank (
    .i_clk   (i_clk),
    .i_we    (w_bank_we),
    .i_be    (w_bank_be),
    .i_addr  (w_bank_addr),
    .i_wdata (w_bank_wdata),
    .i_re    (w_bank_re),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_uns       <= 1'b0;
      r_off       <= '0;
      r_size      <= SZ_B;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_load <= !i_req_we;
        r_rsp_err  <= w_err;
        r_uns      <= i_req_unsigned;
        r_off      <= w_off_eff;
        r_size     <= w_size;
      end
    end
  end

  // Lane extraction runs on the registered word using the registered access attributes.
  assign w_raw       = w_bank_rdata >> {r_off, 3'b000};
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_valid && r_rsp_err;
  assign o_rsp_rdata = (r_rsp_valid && r_rsp_load && !r_rsp_err)
                       ? WORDL'(extend_load(64'(w_raw), r_size, r_uns)) : '0;

endmodule

// File: tb/tb_rv_dmem.sv
// tb/tb_rv_dmem.sv - self-checking scoreboard bench for rv_dmem (WORDL=32, MEMSIZE='h400)
module tb_rv_dmem;

`ifdef RV_DMEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;
  exp_t q[$];

  rv_dmem #(.MEMSIZE('h400), .WORDL(32)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_init_busy    (init_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        exp_t m;
        m = q.pop_front();
        check({m.tag, "_missed"}, 32'd0, 32'd1);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check({e.tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
      end else begin
        check("idle_valid", {31'd0, rsp_valid}, 32'd0);
      end
    end
  end

  // Called at a negedge with the DUT ready; leaves the bench one negedge later.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.due   = cyc + 1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.tag   = tag;
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cycles"}, n, 256);
    check({tag, "_busy"}, {31'd0, init_busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy",  {31'd0, init_busy}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err",   {31'd0, rsp_err}, 32'd0);
    mon_en = 1'b1;
    reset  = 1'b0;
    wait_sweep("sweep1");

    issue("ld_3fc", 1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0, 32'h0000_0000, 1'b0);

    issue("st_10",   1'b1, 2'd2, 1'b0, 10'h010, 32'h8081_8283, 32'h0, 1'b0);
    issue("ldb_s11", 1'b0, 2'd0, 1'b0, 10'h011, 32'h0, 32'hFFFF_FF82, 1'b0);
    issue("ldb_u11", 1'b0, 2'd0, 1'b1, 10'h011, 32'h0, 32'h0000_0082, 1'b0);
    issue("ldh_s12", 1'b0, 2'd1, 1'b0, 10'h012, 32'h0, 32'hFFFF_8081, 1'b0);
    issue("ldw_u10", 1'b0, 2'd2, 1'b1, 10'h010, 32'h0, 32'h8081_8283, 1'b0);

    issue("st_20",   1'b1, 2'd2, 1'b0, 10'h020, 32'h1122_3344, 32'h0, 1'b0);
    issue("stb_23",  1'b1, 2'd0, 1'b0, 10'h023, 32'h0000_00AB, 32'h0, 1'b0);
    issue("ldw_20",  1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 32'hAB22_3344, 1'b0);

    issue("stw_22",  1'b1, 2'd2, 1'b0, 10'h022, 32'hDEAD_BEEF, 32'h0, CHK);
    issue("ldw_20b", 1'b0, 2'd2, 1'b0, 10'h020, 32'h0,
          CHK ? 32'hAB22_3344 : 32'hDEAD_BEEF, 1'b0);

    issue("st_30",   1'b1, 2'd2, 1'b0, 10'h030, 32'hCAFE_F00D, 32'h0, 1'b0);
    issue("ld_30",   1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 32'hCAFE_F00D, 1'b0);
    issue("sth_36",  1'b1, 2'd1, 1'b0, 10'h036, 32'hFFFF_1234, 32'h0, 1'b0);
    issue("ldh_u36", 1'b0, 2'd1, 1'b1, 10'h036, 32'h0, 32'h0000_1234, 1'b0);
    issue("ldw_34",  1'b0, 2'd2, 1'b0, 10'h034, 32'h0, 32'h1234_0000, 1'b0);

    issue("std_40",  1'b1, 2'd3, 1'b0, 10'h040, 32'h5566_7788, 32'h0, CHK);
    issue("ldw_40",  1'b0, 2'd2, 1'b0, 10'h040, 32'h0,
          CHK ? 32'h0000_0000 : 32'h5566_7788, 1'b0);
    issue("ldd_40",  1'b0, 2'd3, 1'b0, 10'h040, 32'h0,
          CHK ? 32'h0000_0000 : 32'h5566_7788, CHK);

    repeat (2) @(negedge clk);
    check("drain1", q.size(), 0);

    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    check("sweep_mid_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_sweep("sweep2");

    issue("ld_10_clr", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'h0000_0000, 1'b0);
    issue("ld_30_clr", 1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 32'h0000_0000, 1'b0);
    repeat (2) @(negedge clk);
    check("drain2", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
